// File: rtl/dcm_freq_ctrl.sv
// Push-button/switch front end for the clock manager: synchronizes and debounces
// three buttons, turns presses into one-cycle update requests and waits for the ack.

module dcm_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Level flips on the edge that would take the disagreement count to DEBOUNCE_CYCLES;
  // press is registered so it is high for the single cycle after a rising flip.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= s2;
        press <= s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module dcm_freq_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ACK_TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_load,
  input  logic [2:0] sw,
  input  logic [2:0] prog_out,
  output logic       update,
  output logic [2:0] prog_in,
  output logic       busy,
  output logic       err
);
  localparam int NUM_BTN = 3;
  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_LOAD = 2;
  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  logic [NUM_BTN-1:0] raw_btn;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [2:0]         sw_s1, sw_s2;

  state_t        state, state_n;
  logic [2:0]    prog_in_n;
  logic          update_n;
  logic          err_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          ev_any;
  logic [2:0]    target;

  assign raw_btn = {btn_load, btn_down, btn_up};

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_btn
      dcm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw_btn[g]),
        .level(btn_level[g]),
        .press(btn_press[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  // Same-cycle presses resolve load > up > down; the losers are simply discarded.
  assign ev_any = |btn_press;
  always_comb begin
    target = prog_in - 3'd1;
    if (btn_press[BTN_LOAD])    target = sw_s2;
    else if (btn_press[BTN_UP]) target = prog_in + 3'd1;
  end

  always_comb begin
    state_n   = state;
    prog_in_n = prog_in;
    update_n  = 1'b0;
    err_n     = err;
    tcnt_n    = tcnt;
    case (state)
      ST_IDLE: begin
        if (ev_any) begin
          prog_in_n = target;
          update_n  = 1'b1;
          state_n   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tcnt_n  = '0;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (prog_out == prog_in) begin
          err_n   = 1'b0;
          state_n = ST_IDLE;
        end else if (tcnt == TMO_LAST) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      prog_in <= '0;
      update  <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      tcnt    <= '0;
    end else begin
      state   <= state_n;
      prog_in <= prog_in_n;
      update  <= update_n;
      busy    <= (state_n != ST_IDLE);
      err     <= err_n;
      tcnt    <= tcnt_n;
    end
  end

  // Debounced levels are only consumed as edges; keep them observable for lint.
  logic unused_level;
  assign unused_level = ^btn_level;
endmodule

// File: tb/tb_dcm_freq_ctrl.sv
// Scoreboard bench for dcm_freq_ctrl with short debounce/timeout parameters.

module tb_dcm_freq_ctrl;
  localparam int DEB = 4;
  localparam int ACK = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_load = 1'b0;
  logic [2:0] sw = 3'd0;
  logic [2:0] prog_out = 3'd0;
  logic       update, busy, err;
  logic [2:0] prog_in;

  int         errors = 0;
  int         checks = 0;
  int         upd_cnt = 0;
  bit         echo_en = 1'b1;
  logic [2:0] sb[$];
  logic [2:0] sb_exp;
  logic [2:0] model = 3'd0;

  dcm_freq_ctrl #(.DEBOUNCE_CYCLES(DEB), .ACK_TIMEOUT(ACK)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_load(btn_load),
    .sw(sw), .prog_out(prog_out), .update(update), .prog_in(prog_in), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Every update pops the code expected when the stimulus was driven.
  always @(negedge clk) begin
    if (!rst && update === 1'b1) begin
      upd_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_update prog_in=%0d but no request was expected", prog_in);
      end else begin
        sb_exp = sb.pop_front();
        if (prog_in !== sb_exp) begin
          errors++;
          $display("FAIL sb_prog_in got=%0d exp=%0d", prog_in, sb_exp);
        end
      end
    end
  end

  // Clock-manager model: reports the requested code two cycles after update.
  initial forever begin
    @(negedge clk);
    if (update === 1'b1 && echo_en) begin
      @(posedge clk);
      @(posedge clk);
      #1;
      if (echo_en) prog_out = prog_in;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_up = v;
      1: btn_down = v;
      default: btn_load = v;
    endcase
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout busy=%b exp=0", busy);
    end
  endtask

  task automatic wait_update(input string name);
    int n = 0;
    @(negedge clk);
    while (update !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (update !== 1'b1) begin
      errors++;
      $display("FAIL %s update=%b exp=1 within 50 cycles", name, update);
    end
  endtask

  task automatic press(input int b, input bit want);
    step();
    set_btn(b, 1'b1);
    if (want) sb.push_back(model);
    repeat (12) step();
    set_btn(b, 1'b0);
    repeat (10) step();
    wait_idle();
  endtask

  task automatic chk_code(input string name);
    checks++;
    if (prog_in !== model) begin
      errors++;
      $display("FAIL %s prog_in=%0d exp=%0d", name, prog_in, model);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({update, prog_in, busy, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs upd=%b prog_in=%0d busy=%b err=%b exp all 0", update, prog_in, busy, err);
    end
    step();
    rst = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_up_press();
    @(posedge clk);
    #1;
    btn_up = 1'b1;
    model = model + 3'd1;
    sb.push_back(model);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (update !== (k == 7)) begin
        errors++;
        $display("FAIL up_update_timing edge=%0d update=%b exp=%b", k, update, (k == 7));
      end
      checks++;
      if (busy !== (k >= 7 && k <= 9)) begin
        errors++;
        $display("FAIL up_busy_timing edge=%0d busy=%b exp=%b", k, busy, (k >= 7 && k <= 9));
      end
    end
    step();
    btn_up = 1'b0;
    repeat (10) step();
    chk_code("up_first");
    for (int i = 0; i < 7; i++) begin
      model = model + 3'd1;
      press(0, 1'b1);
    end
    chk_code("up_wrap");
  endtask

  task automatic test_down_load();
    model = model - 3'd1;
    press(1, 1'b1);
    chk_code("down_wrap");
    sw = 3'd3;
    repeat (4) step();
    model = 3'd3;
    press(2, 1'b1);
    chk_code("load_sw3");
  endtask

  task automatic test_bounce_priority();
    int c0 = upd_cnt;
    step();
    btn_up = 1'b1;
    repeat (3) step();
    btn_up = 1'b0;
    repeat (15) step();
    checks++;
    if (upd_cnt !== c0) begin
      errors++;
      $display("FAIL bounce_rejected updates=%0d exp=%0d", upd_cnt - c0, 0);
    end
    chk_code("bounce_code");
    sw = 3'd5;
    repeat (4) step();
    c0 = upd_cnt;
    model = 3'd5;
    step();
    btn_load = 1'b1;
    btn_up = 1'b1;
    sb.push_back(model);
    repeat (12) step();
    btn_load = 1'b0;
    btn_up = 1'b0;
    repeat (10) step();
    wait_idle();
    checks++;
    if (upd_cnt !== c0 + 1) begin
      errors++;
      $display("FAIL priority_single updates=%0d exp=1", upd_cnt - c0);
    end
    chk_code("priority_load");
  endtask

  task automatic test_timeout();
    int nb = 0;
    echo_en = 1'b0;
    step();
    prog_out = 3'd0;
    model = model + 3'd1;
    btn_up = 1'b1;
    sb.push_back(model);
    wait_update("tmo_update");
    while (busy === 1'b1 && nb < 50) begin
      nb++;
      @(negedge clk);
    end
    checks++;
    if (nb !== 1 + ACK) begin
      errors++;
      $display("FAIL tmo_busy_len busy_cycles=%0d exp=%0d", nb, 1 + ACK);
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_err err=%b busy=%b exp err=1 busy=0", err, busy);
    end
    chk_code("tmo_code_kept");
    step();
    btn_up = 1'b0;
    repeat (10) step();
    echo_en = 1'b1;
    model = model - 3'd1;
    press(1, 1'b1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_recover err=%b exp=0", err);
    end
    chk_code("tmo_recover_code");
  endtask

  task automatic test_drop_reset();
    int c0 = upd_cnt;
    echo_en = 1'b0;
    model = model + 3'd1;
    step();
    btn_up = 1'b1;
    sb.push_back(model);
    wait_update("drop_update");
    step();
    btn_down = 1'b1;
    repeat (12) step();
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (10) step();
    wait_idle();
    checks++;
    if (upd_cnt !== c0 + 1) begin
      errors++;
      $display("FAIL drop_in_wait updates=%0d exp=1", upd_cnt - c0);
    end
    chk_code("drop_code");
    model = model + 3'd1;
    step();
    btn_up = 1'b1;
    sb.push_back(model);
    wait_update("rst_update");
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_wait busy=%b exp=1", busy);
    end
    rst = 1'b1;
    btn_up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({update, prog_in, busy, err} !== 6'b0) begin
        errors++;
        $display("FAIL rst_mid_wait cyc=%0d upd=%b prog_in=%0d busy=%b err=%b exp all 0",
                 i, update, prog_in, busy, err);
      end
    end
    step();
    rst = 1'b0;
    model = 3'd0;
    prog_out = 3'd0;
    echo_en = 1'b1;
    repeat (5) step();
  endtask

  initial begin
    test_reset();
    test_up_press();
    test_down_load();
    test_bounce_priority();
    test_timeout();
    test_drop_reset();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL sb_leftover pending=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
